uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Controller between the UART receiver/transmitter pair and a combinational ALU.
- Collects three bytes from RX in order: operand A, operand B, opcode.
- Presents them to the ALU, then launches TX with the ALU result as a one-byte reply.
- Sits in the UART top in place of the direct RX-to-TX echo path; shares CLK with the baud generator.

Parameters:
- NBIT_DATA, 8: width of RX/TX data, operands and result.
- NBIT_OP, 6: opcode width, taken from rx_data[NBIT_OP-1:0].
- TIMEOUT_CYCLES, 50000000: CLK cycles allowed between bytes of one command before the sequence aborts. Minimum 2.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle pulse from RX: byte available on rx_data.
- rx_data  in  NBIT_DATA  received byte, valid while rx_done_tick=1.
- tx_done_tick  in  1  one-cycle pulse from TX: stop bit finished.
- alu_result  in  NBIT_DATA  combinational ALU output.
- operand_a  out  NBIT_DATA  registered operand A to ALU.
- operand_b  out  NBIT_DATA  registered operand B to ALU.
- opcode  out  NBIT_OP  registered opcode to ALU.
- tx_start  out  1  one-cycle pulse to TX.
- tx_data  out  NBIT_DATA  registered byte to TX, stable from tx_start until the next command result.
- busy  out  1  high in EXEC and WAIT_TX.
- timeout  out  1  one-cycle pulse when a partial command is aborted.
- rx_drop  out  1  one-cycle pulse when a byte arrives while busy and is discarded.

Behaviour:
- Reset (asynchronous, applies immediately, including mid-command or mid-transmission):
  - state=WAIT_A; operand_a, operand_b, opcode, tx_data = 0; tx_start, timeout, rx_drop = 0; timeout counter = 0.
  - A TX already in progress is not aborted by this block.
  - A tx_done_tick arriving after reset is ignored.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX. Registered outputs; busy decoded from state.
- WAIT_A: on rx_done_tick, operand_a<=rx_data, go to WAIT_B. No timeout in this state; counter held at 0.
- WAIT_B: on rx_done_tick, operand_b<=rx_data, go to WAIT_OP, counter<=0.
- WAIT_OP: on rx_done_tick, opcode<=rx_data[NBIT_OP-1:0] (upper bits discarded), go to EXEC, counter<=0.
- EXEC: one settle cycle for the ALU. Next edge: tx_data<=alu_result, tx_start<=1, go to WAIT_TX.
- WAIT_TX: tx_start deasserts after exactly one cycle. On tx_done_tick, go to WAIT_A.
- Latency: if opcode rx_done_tick is sampled at edge N, then state=EXEC after N, tx_start=1 after N+1, tx_start=0 after N+2.
- Timeout (WAIT_B, WAIT_OP):
  - Counter increments every cycle without rx_done_tick.
  - When the counter equals TIMEOUT_CYCLES-1 with no rx_done_tick that cycle: go to WAIT_A, counter<=0, timeout pulses one cycle.
  - Operand and opcode registers keep their values.
  - Counter width is clog2(TIMEOUT_CYCLES); it never wraps.
- Simultaneous rx_done_tick and timeout terminal count: the byte wins (latched, advance, counter cleared, no timeout pulse).
- rx_done_tick in EXEC or WAIT_TX: byte discarded, rx_drop pulses one cycle, state unaffected.
- tx_done_tick outside WAIT_TX: ignored.
- rx_done_tick and tx_done_tick in the same cycle in WAIT_TX: go to WAIT_A, rx_drop=1, byte not latched.
- Back-to-back commands: the first byte of the next command is accepted from the first cycle back in WAIT_A.
- operand/opcode outputs change only on their own latch events and on reset.

Test Plan:
- Bench ALU model: result=a+b for opcode 0x20, a-b for 0x22, a&b for 0x24. Reduced TIMEOUT_CYCLES=20 where timeouts are tested.
- Add: send 0x05, 0x03, 0x20 -> operand_a=0x05, operand_b=0x03, opcode=0x20. tx_start one-cycle pulse two edges after the opcode tick, tx_data=0x08, busy=1 until tx_done_tick.
- Wrap and opcode truncation: send 0xFF, 0x02, 0xE0 -> opcode=0x20, tx_data=0x01 (8-bit wrap). Follow with 0x0A, 0x04, 0x22 -> tx_data=0x06, no spurious tx_start between commands.
- Timeout (TIMEOUT_CYCLES=20): send 0x11, then idle 19 cycles -> timeout pulse, state WAIT_A, operand_a still 0x11. Then 0x01, 0x02, 0x24 -> tx_data=0x00. Byte on exactly the terminal cycle -> no timeout, advance to WAIT_OP.
- Drop while busy: send 0x01, 0x01, 0x20; inject rx_done_tick with 0x77 during WAIT_TX -> rx_drop pulse, operand_a unchanged. The next command is parsed correctly from its first byte after tx_done_tick.
- Reset mid-command: assert reset asynchronously in WAIT_OP -> all outputs 0 immediately, state WAIT_A. A stray tx_done_tick afterwards causes no change. A following full command completes normally.
- Spurious tx_done_tick in WAIT_A/WAIT_B -> no state change, no tx_start.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and an opcode from the UART receiver, lets the ALU settle,
// then launches a one-byte transmission of the ALU result.
module uart_alu_sequencer #(
   parameter int NBIT_DATA      = 8,
   parameter int NBIT_OP        = 6,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 rx_done_tick,
   input  logic [NBIT_DATA-1:0] rx_data,
   input  logic                 tx_done_tick,
   input  logic [NBIT_DATA-1:0] alu_result,
   output logic [NBIT_DATA-1:0] operand_a,
   output logic [NBIT_DATA-1:0] operand_b,
   output logic [NBIT_OP-1:0]   opcode,
   output logic                 tx_start,
   output logic [NBIT_DATA-1:0] tx_data,
   output logic                 busy,
   output logic                 timeout,
   output logic                 rx_drop
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      EXEC,
      WAIT_TX
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [NBIT_DATA-1:0] operand_a_nxt, operand_b_nxt, tx_data_nxt;
   logic [NBIT_OP-1:0]   opcode_nxt;
   logic                 tx_start_nxt, timeout_nxt, rx_drop_nxt;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state     <= WAIT_A;
         cnt       <= '0;
         operand_a <= '0;
         operand_b <= '0;
         opcode    <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         timeout   <= 1'b0;
         rx_drop   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         operand_a <= operand_a_nxt;
         operand_b <= operand_b_nxt;
         opcode    <= opcode_nxt;
         tx_data   <= tx_data_nxt;
         tx_start  <= tx_start_nxt;
         timeout   <= timeout_nxt;
         rx_drop   <= rx_drop_nxt;
      end
   end

   // A byte arriving on the terminal-count cycle takes priority over the abort.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = '0;
      operand_a_nxt = operand_a;
      operand_b_nxt = operand_b;
      opcode_nxt    = opcode;
      tx_data_nxt   = tx_data;
      tx_start_nxt  = 1'b0;
      timeout_nxt   = 1'b0;
      rx_drop_nxt   = 1'b0;
      case (state)
         WAIT_A: begin
            if (rx_done_tick) begin
               operand_a_nxt = rx_data;
               state_nxt     = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done_tick) begin
               operand_b_nxt = rx_data;
               state_nxt     = WAIT_OP;
            end else if (cnt == CNT_LAST) begin
               timeout_nxt = 1'b1;
               state_nxt   = WAIT_A;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               opcode_nxt = rx_data[NBIT_OP-1:0];
               state_nxt  = EXEC;
            end else if (cnt == CNT_LAST) begin
               timeout_nxt = 1'b1;
               state_nxt   = WAIT_A;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         EXEC: begin
            rx_drop_nxt  = rx_done_tick;
            tx_data_nxt  = alu_result;
            tx_start_nxt = 1'b1;
            state_nxt    = WAIT_TX;
         end
         WAIT_TX: begin
            rx_drop_nxt = rx_done_tick;
            if (tx_done_tick) begin
               state_nxt = WAIT_A;
            end
         end
         default: begin
            state_nxt = WAIT_A;
         end
      endcase
   end

   assign busy = (state == EXEC) || (state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench for uart_alu_sequencer: stimulus queues expected TX bytes, a monitor
// checks each tx_start pulse against the queue, plus direct checks of pulses and registers.
module tb_uart_alu_sequencer;

   localparam int NB = 8;
   localparam int NO = 6;
   localparam int TO = 20;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic          rx_done_tick = 1'b0;
   logic [NB-1:0] rx_data = '0;
   logic          tx_done_tick = 1'b0;
   logic [NB-1:0] alu_result;
   logic [NB-1:0] operand_a, operand_b, tx_data;
   logic [NO-1:0] opcode;
   logic          tx_start, busy, timeout, rx_drop;

   typedef struct {
      logic [NB-1:0] data;
      int            cycle;
   } exp_t;

   exp_t sb_q[$];
   int   cycle_cnt = 0;
   int   checks_total = 0;
   int   checks_passed = 0;

   uart_alu_sequencer #(
      .NBIT_DATA(NB),
      .NBIT_OP(NO),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(CLK),
      .reset(reset),
      .rx_done_tick(rx_done_tick),
      .rx_data(rx_data),
      .tx_done_tick(tx_done_tick),
      .alu_result(alu_result),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .opcode(opcode),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .busy(busy),
      .timeout(timeout),
      .rx_drop(rx_drop)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

   // Reference ALU: add, subtract, and.
   always_comb begin
      alu_result = '0;
      case (opcode)
         6'h20:   alu_result = operand_a + operand_b;
         6'h22:   alu_result = operand_a - operand_b;
         6'h24:   alu_result = operand_a & operand_b;
         default: alu_result = '0;
      endcase
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic send_byte(input logic [NB-1:0] d);
      rx_data      = d;
      rx_done_tick = 1'b1;
      @(negedge CLK);
      rx_done_tick = 1'b0;
   endtask

   task automatic pulse_tx_done();
      tx_done_tick = 1'b1;
      @(negedge CLK);
      tx_done_tick = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                 input logic [NB-1:0] op, input logic [NB-1:0] exp_res);
      logic [NO-1:0] exp_op;
      exp_t          e;
      exp_op = op[NO-1:0];
      send_byte(a);
      send_byte(b);
      send_byte(op);
      e.data  = exp_res;
      e.cycle = cycle_cnt + 1;
      sb_q.push_back(e);
      check_output("operand_a", 32'(operand_a), 32'(a));
      check_output("operand_b", 32'(operand_b), 32'(b));
      check_output("opcode", 32'(opcode), 32'(exp_op));
      check_output("busy_exec", 32'(busy), 32'h1);
   endtask

   task automatic finish_tx();
      @(negedge CLK);
      @(negedge CLK);
      check_output("busy_wait_tx", 32'(busy), 32'h1);
      pulse_tx_done();
      check_output("busy_after_done", 32'(busy), 32'h0);
   endtask

   // Monitor: every cycle with tx_start high must match the oldest pending result.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (tx_start) begin
            if (sb_q.size() == 0) begin
               checks_total++;
               $display("[TB] FAIL spurious_tx_start: got tx_start=1 tx_data=0x%0h, expected no pulse (t=%0t)",
                        tx_data, $time);
            end else begin
               e = sb_q.pop_front();
               check_output("tx_data", 32'(tx_data), 32'(e.data));
               check_output("tx_start_cycle", 32'(cycle_cnt), 32'(e.cycle));
            end
         end
      end
   end

   initial begin
      int pulses;
      repeat (2) @(negedge CLK);
      check_output("rst_operand_a", 32'(operand_a), 32'h0);
      check_output("rst_opcode", 32'(opcode), 32'h0);
      check_output("rst_tx_data", 32'(tx_data), 32'h0);
      check_output("rst_busy", 32'(busy), 32'h0);
      check_output("rst_pulses", {29'h0, tx_start, timeout, rx_drop}, 32'h0);
      reset = 1'b0;
      @(negedge CLK);

      $display("[TB] add");
      apply_stimulus(8'h05, 8'h03, 8'h20, 8'h08);
      finish_tx();

      $display("[TB] wrap and opcode truncation");
      apply_stimulus(8'hFF, 8'h02, 8'hE0, 8'h01);
      finish_tx();
      apply_stimulus(8'h0A, 8'h04, 8'h22, 8'h06);
      finish_tx();

      $display("[TB] timeout");
      send_byte(8'h11);
      pulses = 0;
      for (int i = 0; i < TO - 1; i++) begin
         @(negedge CLK);
         if (timeout) pulses++;
      end
      check_output("timeout_early", 32'(pulses), 32'h0);
      @(negedge CLK);
      check_output("timeout_pulse", 32'(timeout), 32'h1);
      check_output("timeout_operand_a", 32'(operand_a), 32'h11);
      @(negedge CLK);
      check_output("timeout_one_cycle", 32'(timeout), 32'h0);
      apply_stimulus(8'h01, 8'h02, 8'h24, 8'h00);
      finish_tx();

      $display("[TB] byte on terminal count");
      send_byte(8'h33);
      repeat (TO - 1) @(negedge CLK);
      send_byte(8'h44);
      check_output("terminal_no_timeout", 32'(timeout), 32'h0);
      check_output("terminal_operand_b", 32'(operand_b), 32'h44);
      send_byte(8'h20);
      sb_q.push_back('{8'h77, cycle_cnt + 1});
      check_output("terminal_opcode", 32'(opcode), 32'h20);
      finish_tx();

      $display("[TB] drop while busy");
      apply_stimulus(8'h01, 8'h01, 8'h20, 8'h02);
      @(negedge CLK);
      send_byte(8'h77);
      check_output("rx_drop_pulse", 32'(rx_drop), 32'h1);
      check_output("drop_operand_a", 32'(operand_a), 32'h01);
      @(negedge CLK);
      check_output("rx_drop_one_cycle", 32'(rx_drop), 32'h0);
      pulse_tx_done();
      check_output("drop_busy_cleared", 32'(busy), 32'h0);
      apply_stimulus(8'h09, 8'h03, 8'h22, 8'h06);
      finish_tx();

      $display("[TB] reset mid-command");
      send_byte(8'h12);
      send_byte(8'h34);
      #2 reset = 1'b1;
      #1;
      check_output("async_rst_operand_a", 32'(operand_a), 32'h0);
      check_output("async_rst_operand_b", 32'(operand_b), 32'h0);
      check_output("async_rst_opcode", 32'(opcode), 32'h0);
      check_output("async_rst_tx_data", 32'(tx_data), 32'h0);
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      pulse_tx_done();
      check_output("stray_done_busy", 32'(busy), 32'h0);
      apply_stimulus(8'h07, 8'h08, 8'h20, 8'h0F);
      finish_tx();

      $display("[TB] spurious tx_done in WAIT_A/WAIT_B");
      pulse_tx_done();
      check_output("spur_done_wait_a", 32'(busy), 32'h0);
      send_byte(8'h05);
      pulse_tx_done();
      check_output("spur_done_wait_b", 32'(busy), 32'h0);
      send_byte(8'h06);
      send_byte(8'h24);
      sb_q.push_back('{8'h04, cycle_cnt + 1});
      check_output("spur_operand_a", 32'(operand_a), 32'h05);
      check_output("spur_operand_b", 32'(operand_b), 32'h06);
      finish_tx();

      repeat (3) @(negedge CLK);
      check_output("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
